// File: rtl/div_n_bit_seq_pkg.sv
// Purpose: shared types and constants for the sequential restoring divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package div_n_bit_seq_pkg;

  // Default operand width; legal range is 2..64.
  localparam int DEFAULT_WORD_SIZE = 32;

  // Divider control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Iteration counter width: clog2(word_size), never narrower than one bit.
  function automatic int cnt_width(input int ws);
    return (ws < 2) ? 1 : $clog2(ws);
  endfunction

endpackage

// File: rtl/div_trial_sub.sv
// Purpose: (word_size+1)-bit ripple borrow subtractor, a - b computed as a + ~b + 1.
// Latency: combinational.
// Backpressure: none.
module div_trial_sub
  import div_n_bit_seq_pkg::*;
#(
  parameter int width = DEFAULT_WORD_SIZE + 1
) (
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  output logic [width-1:0] diff,
  output logic             borrow
);

  logic [width:0] carry;

  // Ripple adder chain with the subtrahend inverted and carry-in forced to 1;
  // a missing carry-out means a < b, i.e. a borrow.
  always_comb begin
    carry    = '0;
    diff     = '0;
    carry[0] = 1'b1;
    for (int i = 0; i < width; i++) begin
      diff[i]      = a[i] ^ ~b[i] ^ carry[i];
      carry[i + 1] = (a[i] & ~b[i]) | (carry[i] & (a[i] ^ ~b[i]));
    end
    borrow = ~carry[width];
  end

endmodule

// File: rtl/div_n_bit_seq.sv
// Purpose: sequential unsigned restoring divider, one quotient bit per clock.
// Latency: done word_size+1 cycles after an accepted start (1 cycle for a zero divisor).
// Backpressure: start is only sampled in IDLE; requests while busy are dropped, not queued.
module div_n_bit_seq
  import div_n_bit_seq_pkg::*;
#(
  parameter int word_size = DEFAULT_WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [word_size-1:0] R2,
  input  logic [word_size-1:0] R3,
  output logic                 busy,
  output logic                 done,
  output logic [word_size-1:0] DIV_out,
  output logic [word_size-1:0] REM_out,
  output logic                 div_by_zero
);

  localparam int            CW       = cnt_width(word_size);
  localparam logic [CW-1:0] LAST_CNT = CW'(word_size - 1);

  div_state_t state, state_nxt;

  logic [word_size-1:0] divisor;
  logic [word_size-1:0] quo;
  // The partial remainder is always below the divisor between steps, so it
  // fits in word_size bits; only the shifted trial value needs the extra bit.
  logic [word_size-1:0] rem;
  logic [CW-1:0]        cnt;

  logic [word_size:0]   rem_shift;
  logic [word_size:0]   trial;
  logic                 borrow;
  logic [word_size-1:0] rem_nxt;
  logic [word_size-1:0] quo_nxt;
  logic                 unused_trial_msb;

  // One restoring step: shift {rem, quo} left, try rem - divisor.
  assign rem_shift = {rem, quo[word_size-1]};

  div_trial_sub #(
    .width (word_size + 1)
  ) u_trial_sub (
    .a      (rem_shift),
    .b      ({1'b0, divisor}),
    .diff   (trial),
    .borrow (borrow)
  );

  // Restore on borrow, otherwise keep the difference and record a 1 bit.
  assign rem_nxt = borrow ? rem_shift[word_size-1:0] : trial[word_size-1:0];
  assign quo_nxt = {quo[word_size-2:0], ~borrow};

  // A successful trial is always below the divisor, so its top bit is zero.
  assign unused_trial_msb = trial[word_size];

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode: zero divisor skips straight to DONE; DONE always returns to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (R3 == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        if (cnt == LAST_CNT) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, and result latch; results hold until the next latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      divisor     <= '0;
      quo         <= '0;
      rem         <= '0;
      cnt         <= '0;
      DIV_out     <= '0;
      REM_out     <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (R3 == '0) begin
              DIV_out     <= '1;
              REM_out     <= R2;
              div_by_zero <= 1'b1;
            end else begin
              divisor <= R3;
              quo     <= R2;
              rem     <= '0;
              cnt     <= '0;
            end
          end
        end
        CALC: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            DIV_out     <= quo_nxt;
            REM_out     <= rem_nxt;
            div_by_zero <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_n_bit_seq.sv
module tb_div_n_bit_seq;

  localparam int WS  = 32;
  localparam int LAT = WS + 1;

  logic          clk;
  logic          rst;
  logic          start;
  logic [WS-1:0] R2;
  logic [WS-1:0] R3;
  logic          busy;
  logic          done;
  logic [WS-1:0] DIV_out;
  logic [WS-1:0] REM_out;
  logic          div_by_zero;

  int errors = 0;
  int checks = 0;

  div_n_bit_seq #(.word_size(WS)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .R2          (R2),
    .R3          (R3),
    .busy        (busy),
    .done        (done),
    .DIV_out     (DIV_out),
    .REM_out     (REM_out),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "timeout");
  end

  // Reference: plain integer division, with the zero-divisor convention.
  function automatic void ref_div(input logic [WS-1:0] a, input logic [WS-1:0] b,
                                  output logic [WS-1:0] q, output logic [WS-1:0] r,
                                  output logic z, output int lat);
    if (b == 0) begin
      q = '1; r = a; z = 1'b1; lat = 1;
    end else begin
      q = a / b; r = a % b; z = 1'b0; lat = LAT;
    end
  endfunction

  // Launch one division from an IDLE negedge and observe it up to the cycle after done.
  // lat: cycles from the accepting edge to done; gaps: cycles busy was low before/at done;
  // holds: cycles before done in which the result outputs changed.
  task automatic do_div(input logic [WS-1:0] a, input logic [WS-1:0] b,
                        output int lat, output logic [WS-1:0] q, output logic [WS-1:0] r,
                        output logic z, output int gaps, output int holds);
    logic [WS-1:0] pq, pr;
    logic          pz;
    pq = DIV_out; pr = REM_out; pz = div_by_zero;
    start = 1'b1; R2 = a; R3 = b;
    @(negedge clk);
    start = 1'b0; R2 = $urandom; R3 = $urandom;
    lat = 1; gaps = 0; holds = 0;
    while (!done && lat < 200) begin
      if (!busy) gaps++;
      if (DIV_out !== pq || REM_out !== pr || div_by_zero !== pz) holds++;
      @(negedge clk);
      lat++;
    end
    if (!busy) gaps++;
    q = DIV_out; r = REM_out; z = div_by_zero;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; R2 = '0; R3 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (DIV_out !== '0) begin errors++; $display("FAIL reset_div: got %0h want 0", DIV_out); end
    checks++; if (REM_out !== '0) begin errors++; $display("FAIL reset_rem: got %0h want 0", REM_out); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %b want 0", div_by_zero); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [WS-1:0] ta [3];
    logic [WS-1:0] tb [3];
    logic [WS-1:0] tq [3];
    logic [WS-1:0] tr [3];
    int lat, gaps, holds;
    logic [WS-1:0] q, r;
    logic z;
    ta[0] = 100;           tb[0] = 7; tq[0] = 14;            tr[0] = 2;
    ta[1] = 32'hFFFF_FFFF; tb[1] = 1; tq[1] = 32'hFFFF_FFFF; tr[1] = 0;
    ta[2] = 7;             tb[2] = 9; tq[2] = 0;             tr[2] = 7;
    for (int i = 0; i < 3; i++) begin
      do_div(ta[i], tb[i], lat, q, r, z, gaps, holds);
      checks++; if (q !== tq[i]) begin errors++; $display("FAIL basic_q[%0d]: got %0h want %0h", i, q, tq[i]); end
      checks++; if (r !== tr[i]) begin errors++; $display("FAIL basic_r[%0d]: got %0h want %0h", i, r, tr[i]); end
      checks++; if (z !== 1'b0) begin errors++; $display("FAIL basic_dbz[%0d]: got %b want 0", i, z); end
      checks++; if (lat != LAT) begin errors++; $display("FAIL basic_lat[%0d]: got %0d want %0d", i, lat, LAT); end
      checks++; if (gaps != 0) begin errors++; $display("FAIL basic_busy[%0d]: busy low %0d cycles, want 0", i, gaps); end
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL basic_idle[%0d]: busy=%b done=%b want 0 0", i, busy, done); end
    end
  endtask

  task automatic test_div_zero();
    int lat, gaps, holds;
    logic [WS-1:0] q, r;
    logic z;
    do_div(5, 0, lat, q, r, z, gaps, holds);
    checks++; if (lat != 1) begin errors++; $display("FAIL dz_lat: got %0d want 1", lat); end
    checks++; if (z !== 1'b1) begin errors++; $display("FAIL dz_flag: got %b want 1", z); end
    checks++; if (q !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dz_q: got %0h want ffffffff", q); end
    checks++; if (r !== 5) begin errors++; $display("FAIL dz_r: got %0h want 5", r); end
    checks++; if (gaps != 0) begin errors++; $display("FAIL dz_busy: busy low %0d cycles, want 0", gaps); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL dz_idle: busy=%b done=%b want 0 0", busy, done); end
  endtask

  task automatic test_start_ignored();
    int lat, gaps, holds;
    logic [WS-1:0] q, r;
    logic z;
    start = 1'b1; R2 = 100; R3 = 7;
    @(negedge clk);
    start = 1'b0; lat = 1;
    repeat (4) begin @(negedge clk); lat++; end
    start = 1'b1; R2 = 50; R3 = 3;
    @(negedge clk);
    start = 1'b0; lat++;
    while (!done && lat < 200) begin @(negedge clk); lat++; end
    checks++; if (lat != LAT) begin errors++; $display("FAIL ign_lat: got %0d want %0d", lat, LAT); end
    checks++; if (DIV_out !== 14) begin errors++; $display("FAIL ign_q: got %0d want 14", DIV_out); end
    checks++; if (REM_out !== 2) begin errors++; $display("FAIL ign_r: got %0d want 2", REM_out); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_idle: busy=%b want 0", busy); end
    do_div(50, 3, lat, q, r, z, gaps, holds);
    checks++; if (holds != 0) begin errors++; $display("FAIL ign_hold: outputs changed in %0d cycles, want 0", holds); end
    checks++; if (q !== 16) begin errors++; $display("FAIL ign_q2: got %0d want 16", q); end
    checks++; if (r !== 2) begin errors++; $display("FAIL ign_r2: got %0d want 2", r); end
  endtask

  task automatic test_reset_mid();
    int lat, gaps, holds, dones;
    logic [WS-1:0] q, r;
    logic z;
    start = 1'b1; R2 = 100; R3 = 7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rmid_done: got %b want 0", done); end
    checks++; if (DIV_out !== '0) begin errors++; $display("FAIL rmid_q: got %0h want 0", DIV_out); end
    checks++; if (REM_out !== '0) begin errors++; $display("FAIL rmid_r: got %0h want 0", REM_out); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL rmid_dbz: got %b want 0", div_by_zero); end
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    checks++; if (dones != 0) begin errors++; $display("FAIL rmid_abort: busy/done seen %0d cycles after reset, want 0", dones); end
    do_div(1000, 10, lat, q, r, z, gaps, holds);
    checks++; if (q !== 100 || r !== 0) begin errors++; $display("FAIL rmid_next: got %0d r %0d want 100 r 0", q, r); end
    checks++; if (lat != LAT) begin errors++; $display("FAIL rmid_lat: got %0d want %0d", lat, LAT); end
  endtask

  task automatic test_back_to_back();
    int lat, gaps, holds;
    logic [WS-1:0] q, r, eq, er;
    logic z, ez;
    int elat;
    for (int i = 0; i < 4; i++) begin
      logic [WS-1:0] a, b;
      a = $urandom; b = (i == 2) ? '0 : $urandom_range(1, 1000);
      ref_div(a, b, eq, er, ez, elat);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_ready[%0d]: busy=%b want 0", i, busy); end
      do_div(a, b, lat, q, r, z, gaps, holds);
      checks++; if (q !== eq || r !== er || z !== ez || lat != elat) begin
        errors++;
        $display("FAIL b2b[%0d]: got q=%0h r=%0h z=%b lat=%0d want q=%0h r=%0h z=%b lat=%0d", i, q, r, z, lat, eq, er, ez, elat);
      end
    end
  endtask

  task automatic test_random();
    int lat, gaps, holds, elat;
    logic [WS-1:0] a, b, q, r, eq, er;
    logic z, ez;
    logic [63:0] recon;
    for (int i = 0; i < 250; i++) begin
      case ($urandom_range(0, 7))
        0: begin a = $urandom; b = '0; end
        1: begin b = $urandom_range(2, 32'hFFFF_FFFF); a = $urandom_range(0, b - 1); end
        2: begin a = $urandom; b = $urandom_range(1, 15); end
        3: begin a = $urandom_range(0, 255); b = $urandom_range(1, 255); end
        default: begin a = $urandom; b = $urandom; end
      endcase
      ref_div(a, b, eq, er, ez, elat);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_div(a, b, lat, q, r, z, gaps, holds);
      checks++; if (q !== eq) begin errors++; $display("FAIL rnd_q[%0d] %0h/%0h: got %0h want %0h", i, a, b, q, eq); end
      checks++; if (r !== er) begin errors++; $display("FAIL rnd_r[%0d] %0h/%0h: got %0h want %0h", i, a, b, r, er); end
      checks++; if (z !== ez) begin errors++; $display("FAIL rnd_dbz[%0d]: got %b want %b", i, z, ez); end
      checks++; if (lat != elat) begin errors++; $display("FAIL rnd_lat[%0d]: got %0d want %0d", i, lat, elat); end
      checks++; if (holds != 0 || gaps != 0) begin errors++; $display("FAIL rnd_hold[%0d]: changes=%0d busy_gaps=%0d want 0 0", i, holds, gaps); end
      if (b != 0) begin
        recon = 64'(q) * 64'(b) + 64'(r);
        checks++; if (recon !== 64'(a) || r >= b) begin
          errors++; $display("FAIL rnd_inv[%0d]: q*b+r=%0h r=%0h want %0h with r<%0h", i, recon, r, a, b);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
